// File: rtl/counter_4bit_down_reload_if.sv
// Control/status bundle for counter_4bit_down_reload.
//   master: drives en, load, d, reload_en; observes q, tc, done, running.
//   slave : the counter side of the same signals.
// Port summary:
//   en        count enable
//   load      load strobe, captures d into the count and the reload register
//   d         value to load (WIDTH bits)
//   reload_en 1 = periodic auto-reload, 0 = one-shot
//   q         current count (WIDTH bits)
//   tc        terminal-count pulse, one cycle wide
//   done      sticky one-shot completion flag
//   running   high while the counter is actively counting
interface counter_4bit_down_reload_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             en;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             reload_en;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             done;
  logic             running;

  modport master (
    output en, load, d, reload_en,
    input  q, tc, done, running
  );

  modport slave (
    input  en, load, d, reload_en,
    output q, tc, done, running
  );
endinterface

// File: rtl/counter_4bit_down_reload.sv
// Programmable interval timer: counts a loaded value down to zero and flags
// terminal count. One-shot mode stops at zero with a sticky done flag;
// periodic mode reloads the last loaded value and keeps running.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, overrides every other input
//   bus  slave side of counter_4bit_down_reload_if (en, load, d, reload_en
//        in; q, tc, done, running out)
module counter_4bit_down_reload #(
  parameter int unsigned WIDTH = 4
) (
  input logic                       clk,
  input logic                       rst,
  counter_4bit_down_reload_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCount, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    reload_d = reload_q;
    done_d   = done_q;
    tc_d     = 1'b0;  // tc is a single-cycle pulse unless re-asserted below

    if (bus.load) begin
      q_d      = bus.d;
      reload_d = bus.d;
      if (bus.d != '0) begin
        state_d = StCount;
        done_d  = 1'b0;
      end else begin
        // Loading zero expires immediately without a tc pulse.
        state_d = StDone;
        done_d  = 1'b1;
      end
    end else begin
      unique case (state_q)
        StIdle: ;
        StCount: begin
          if (bus.en) begin
            if (q_q > One) begin
              q_d = q_q - One;
            end else if (q_q == One) begin
              tc_d = 1'b1;
              if (bus.reload_en) begin
                // Periodic: jump straight to the reload value, never showing 0.
                q_d = reload_q;
              end else begin
                q_d     = '0;
                done_d  = 1'b1;
                state_d = StDone;
              end
            end
            // q_q == 0 cannot occur in StCount; hold rather than wrap.
          end
        end
        StDone: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      q_q      <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
      done_q   <= done_d;
    end
  end

  assign bus.q       = q_q;
  assign bus.tc      = tc_q;
  assign bus.done    = done_q;
  assign bus.running = (state_q == StCount);

endmodule

// File: tb/tb_counter_4bit_down_reload.sv
// Scoreboard bench for counter_4bit_down_reload: directed scenarios followed
// by random traffic, all checked against a behavioural timer model.
module tb_counter_4bit_down_reload;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  counter_4bit_down_reload_if #(.WIDTH(4)) bus ();

  counter_4bit_down_reload #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0] q;
    logic       tc;
    logic       done;
    logic       running;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;
  bit   stim_done = 1'b0;

  // Behavioural model: a timer holding an integer count and a mode.
  int m_count  = 0;
  int m_period = 0;
  bit m_active = 0;   // counting
  bit m_done   = 0;
  bit m_tc     = 0;

  task automatic model_step(input bit r, input bit e, input bit l, input int dv, input bit per);
    m_tc = 0;
    if (r) begin
      m_count = 0; m_period = 0; m_active = 0; m_done = 0;
    end else if (l) begin
      m_count  = dv;
      m_period = dv;
      m_active = (dv != 0);
      m_done   = (dv == 0);
    end else if (m_active && e) begin
      m_count = m_count - 1;
      if (m_count == 0) begin
        m_tc = 1;
        if (per) m_count = m_period;
        else begin
          m_active = 0;
          m_done   = 1;
        end
      end
    end
  endtask

  // Drive one cycle of inputs (before the edge) and record the expected result.
  task automatic cycle(input bit r, input bit e, input bit l, input int dv, input bit per);
    exp_t x;
    rst           = r;
    bus.en        = e;
    bus.load      = l;
    bus.d         = 4'(dv);
    bus.reload_en = per;
    model_step(r, e, l, dv, per);
    x.q       = 4'(m_count);
    x.tc      = m_tc;
    x.done    = m_done;
    x.running = m_active;
    sb.push_back(x);
    @(negedge clk);
  endtask

  task automatic check1(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      failed++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  // Monitor: every edge presents a new output tuple.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() != 0) begin
        x = sb.pop_front();
        check1("q", int'(bus.q), int'(x.q));
        check1("tc", int'(bus.tc), int'(x.tc));
        check1("done", int'(bus.done), int'(x.done));
        check1("running", int'(bus.running), int'(x.running));
      end
    end
  end

  initial begin
    bus.en = 0; bus.load = 0; bus.d = '0; bus.reload_en = 0;
    cycle(1, 0, 0, 0, 0);
    // Enable with nothing loaded does nothing.
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0);
    // One-shot from 5.
    cycle(0, 1, 1, 5, 0);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0, 0);
    // Periodic from 3.
    cycle(0, 1, 1, 3, 1);
    for (int i = 0; i < 9; i++) cycle(0, 1, 0, 0, 1);
    // Pause and load-over-enable.
    cycle(0, 1, 1, 12, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 1, 2, 0);
    cycle(0, 1, 0, 0, 0);
    // Load zero, then periodic reload value 1.
    cycle(0, 1, 1, 0, 0);
    cycle(0, 1, 1, 1, 1);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 1);
    // Reset mid-count, then enable without load.
    cycle(0, 1, 1, 9, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0);
    // Random traffic, small load values favoured so terminal count is frequent.
    begin
      bit per = 0;
      for (int i = 0; i < 600; i++) begin
        bit r, e, l;
        int dv;
        r  = ($urandom_range(0, 59) == 0);
        l  = ($urandom_range(0, 9) == 0);
        e  = ($urandom_range(0, 3) != 0);
        dv = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 15);
        if ($urandom_range(0, 15) == 0) per = ~per;
        cycle(r, e, l, dv, per);
      end
    end
    stim_done = 1'b1;
    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    check1("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/counter_4bit_down_reload.md
Name: counter_4bit_down_reload

Overview:
- Down-counting companion to the 4-bit up counter with load. Used as a programmable interval timer: counts a loaded value down to zero and flags terminal count.
- In one-shot mode it stops at zero with a sticky done flag. In periodic mode it reloads the last loaded value automatically and keeps running.
- Sits next to the up counter in the counter_load area; same clk/rst/en/load/d/q interface style, plus status outputs.

Parameters:
- WIDTH, 4, counter and load-value width in bits.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable; one decrement per clk edge while high in COUNT.
- load  input  1  load strobe; captures d into q and the reload register.
- d  input  WIDTH  value to load.
- reload_en  input  1  1 = periodic (auto-reload) mode, 0 = one-shot; sampled each edge.
- q  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered, exactly 1 cycle wide.
- done  output  1  sticky one-shot completion flag, registered.
- running  output  1  high while the FSM is in COUNT (decoded from the state register).

Behaviour:
- One clock domain. Reset is synchronous and active-high; rst sampled high at a clk edge overrides every other input.
- Reset values: q=0, reload register=0, tc=0, done=0, state=IDLE, running=0.
- States:
  - IDLE: after reset; ignores en; q holds 0.
  - COUNT: decrements on en.
  - DONE: one-shot expired; q holds 0; ignores en.
- Load (priority over en in every state):
  - q<=d and reload register<=d; done<=0; tc<=0.
  - Next state is COUNT if d!=0.
  - If d==0, next state is DONE and done<=1; no tc pulse.
- COUNT with en=0: q, state and done hold; tc<=0.
- COUNT with en=1 and q>1: q<=q-1; tc<=0.
- COUNT with en=1 and q==1:
  - reload_en=0: q<=0, tc<=1, done<=1, state<=DONE.
  - reload_en=1: q<=reload register, tc<=1, state stays COUNT, done stays 0.
  - Periodic mode therefore never shows q=0; period = reload value in enabled cycles.
- Reload value 1 in periodic mode: q stays 1 and tc pulses on every enabled edge. This is the only case where tc is high on consecutive cycles.
- tc is high only in the cycle after the edge that reaches terminal count; cleared on the next edge.
- Pausing (en low) never clears tc early beyond its single cycle; tc is still exactly one cycle.
- Switching reload_en mid-count takes effect at the next terminal count only.
- Reset mid-count: state returns to IDLE, q=0, and the reload register is cleared. A later en without load does nothing.
- No wrap-around below zero: q never decrements from 0 in any state.
- Width rule: q-1 is computed at WIDTH bits; the reload register is WIDTH bits.

Test Plan:
- Reset, then en=1 for 5 cycles with no load -> q=0, running=0, tc=0, done=0 throughout.
- Load d=5, reload_en=0, en=1 -> q reads 5,4,3,2,1,0 on successive edges. tc=1 for exactly the cycle q first reads 0; done=1 and running=0 afterwards. Further en leaves q=0.
- Load d=3, reload_en=1, en held high for 9 edges -> q sequence 3,2,1,3,2,1,3,2,1,3. tc pulses on the three edges where q goes 1->3; done stays 0.
- Load d=12, en=1 for 4 edges, en=0 for 3, en=1 again -> q 12,11,10,9,8, holds 8 for 3 cycles, then resumes 7. Assert load with en=1 and d=2 while q=7 -> next q=2 (load wins, no decrement).
- Load d=0 -> q=0, done=1, tc=0, running=0. Load d=1 with reload_en=1, en=1 -> q stays 1 and tc high on every edge.
- Load d=9, en=1 for 3 edges, then rst=1 for one edge -> q=0, tc=0, done=0, running=0 on that edge. With en still high and no load, q remains 0.
